// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, reads the program ROM and feeds
// decode through a 2-entry {pc, word} skid buffer with sticky faults.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned ROM_WORDS = 100
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        fault,
   output logic [31:0] fault_pc
);

   typedef enum logic {
      RUN,
      FAULT
   } state_t;

   localparam logic [32:0] LIMIT = 33'(ROM_WORDS) << 2;

   state_t      state;
   logic [31:0] fetch_pc;
   logic [31:0] pc0;
   logic [31:0] w0;
   logic [31:0] pc1;
   logic [31:0] w1;
   logic [1:0]  count;

   logic pop;
   logic can_push;
   logic in_range;
   logic flush;
   logic push;
   logic range_fault;

   assign rom_addr   = fetch_pc;
   assign inst_valid = (count != 2'd0);
   assign inst       = w0;
   assign inst_pc    = pc0;

   assign pop         = inst_valid & inst_ready;
   assign can_push    = (count != 2'd2) | pop;
   assign in_range    = ({1'b0, fetch_pc} < LIMIT);
   assign flush       = (state == RUN) & redirect_valid;
   assign push        = (state == RUN) & ~redirect_valid
                        & can_push & in_range;
   assign range_fault = (state == RUN) & ~redirect_valid
                        & can_push & ~in_range;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= RUN;
         fetch_pc <= RESET_PC;
         count    <= 2'd0;
         pc0      <= 32'h0;
         w0       <= 32'h0;
         pc1      <= 32'h0;
         w1       <= 32'h0;
         fault    <= 1'b0;
         fault_pc <= 32'h0;
      end else if (flush) begin
         // head is squashed even if decode takes it this cycle
         count <= 2'd0;
         if (redirect_pc[1:0] != 2'b00) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fault_pc <= redirect_pc;
         end else begin
            fetch_pc <= redirect_pc;
         end
      end else begin
         if (range_fault) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fault_pc <= fetch_pc;
         end
         if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  pc0 <= fetch_pc;
                  w0  <= rom_data;
               end else begin
                  pc1 <= fetch_pc;
                  w1  <= rom_data;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               pc0   <= pc1;
               w0    <= w1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  pc0 <= fetch_pc;
                  w0  <= rom_data;
               end else begin
                  pc0 <= pc1;
                  w0  <= w1;
                  pc1 <= fetch_pc;
                  w1  <= rom_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
